// File: rtl/time_report_ctrl_if.sv
// Character stream from the time report controller to a UART transmitter.
// tx_valid/tx_ready: a character moves on any cycle where both are high; while
// tx_valid is high and tx_ready is low, tx_data holds and tx_valid stays high.
interface time_report_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/time_report_ctrl.sv
// Formats a snapshot of the BCD time as "CL hh:mm:ss\r\n" / "SW hh:mm:ss\r\n" for a UART.
// Optional macro TIME_REPORT_AUTO_EN adds periodic reports every AUTO_PERIOD tick_100hz pulses.
module time_report_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int AUTO_PERIOD = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                tick_100hz,
  input  logic                sw_mode,
  input  logic [3:0]          hour1,
  input  logic [3:0]          hour0,
  input  logic [3:0]          min1,
  input  logic [3:0]          min0,
  input  logic [3:0]          sec1,
  input  logic [3:0]          sec0,
  time_report_ctrl_if.master  tx,
  output logic                busy,
  output logic                frame_done,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd12;

  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic       pend, pend_n;
  logic       load;
  logic       start_evt;
  logic       auto_evt;
  logic [7:0] ch;

  logic       snap_mode;
  logic [3:0] snap_h1, snap_h0, snap_m1, snap_m0, snap_s1, snap_s0;

`ifdef TIME_REPORT_AUTO_EN
  localparam int CW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [CW-1:0] WRAP = CW'(AUTO_PERIOD - 1);

  logic [CW-1:0] auto_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      auto_cnt <= '0;
    end else if (tick_100hz) begin
      auto_cnt <= (auto_cnt == WRAP) ? '0 : auto_cnt + CW'(1);
    end
  end

  assign auto_evt = tick_100hz && (auto_cnt == WRAP);
`else
  localparam int unused_period = AUTO_PERIOD;
  logic tick_unused;
  assign tick_unused = tick_100hz;
  assign auto_evt    = 1'b0;
`endif

  // A req and an auto wrap in the same cycle collapse into one event.
  assign start_evt = req | auto_evt;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  always_comb begin
    ch = 8'h00;
    case (idx)
      4'd0:    ch = snap_mode ? 8'h43 : 8'h53;
      4'd1:    ch = snap_mode ? 8'h4C : 8'h57;
      4'd2:    ch = 8'h20;
      4'd3:    ch = digit_char(snap_h1);
      4'd4:    ch = digit_char(snap_h0);
      4'd5:    ch = 8'h3A;
      4'd6:    ch = digit_char(snap_m1);
      4'd7:    ch = digit_char(snap_m0);
      4'd8:    ch = 8'h3A;
      4'd9:    ch = digit_char(snap_s1);
      4'd10:   ch = digit_char(snap_s0);
      4'd11:   ch = 8'h0D;
      4'd12:   ch = 8'h0A;
      default: ch = 8'h00;
    endcase
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pend_n  = pend;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start_evt || pend) begin
          state_n = SEND;
          idx_n   = 4'd0;
          pend_n  = 1'b0;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (start_evt) pend_n = 1'b1;
        if (tx.tx_ready) begin
          if (idx == LAST_IDX) state_n = DONE;
          else                 idx_n   = idx + 4'd1;
        end
      end
      DONE: begin
        if (start_evt) pend_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 4'd0;
      pend      <= 1'b0;
      snap_mode <= 1'b0;
      snap_h1   <= 4'd0;
      snap_h0   <= 4'd0;
      snap_m1   <= 4'd0;
      snap_m0   <= 4'd0;
      snap_s1   <= 4'd0;
      snap_s0   <= 4'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      pend  <= pend_n;
      if (load) begin
        snap_mode <= sw_mode;
        snap_h1   <= hour1;
        snap_h0   <= hour0;
        snap_m1   <= min1;
        snap_m0   <= min0;
        snap_s1   <= sec1;
        snap_s0   <= sec0;
      end
    end
  end

  assign tx.tx_valid = (state == SEND);
  assign tx.tx_data  = (state == SEND) ? DATA_WIDTH'(ch) : '0;
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_time_report_ctrl.sv
// Directed bench for time_report_ctrl: frame content, stalls, snapshotting,
// pending requests, mid-frame reset and the optional auto-report counter.
module tb_time_report_ctrl;

  logic       clk;
  logic       rst;
  logic       req;
  logic       tick_100hz;
  logic       sw_mode;
  logic [3:0] hour1, hour0, min1, min0, sec1, sec0;
  logic       busy;
  logic       frame_done;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  time_report_ctrl_if #(.DATA_WIDTH(8)) tx_if ();

  time_report_ctrl #(
    .DATA_WIDTH (8),
    .AUTO_PERIOD(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .tick_100hz(tick_100hz),
    .sw_mode   (sw_mode),
    .hour1     (hour1),
    .hour0     (hour0),
    .min1      (min1),
    .min0      (min0),
    .sec1      (sec1),
    .sec0      (sec0),
    .tx        (tx_if),
    .busy      (busy),
    .frame_done(frame_done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_time(input logic mode, input logic [3:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0,
                          input logic [3:0] s1, input logic [3:0] s0);
    sw_mode = mode;
    hour1 = h1; hour0 = h0; min1 = m1; min0 = m0; sec1 = s1; sec0 = s0;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  // Called in the first SEND cycle; returns in the DONE cycle.
  task automatic run_frame(input logic [7:0] tbl [13], input int stall_at, input int stall_len,
                           input int chg_at, input logic [12:0] req_at);
    exp_q.delete();
    for (int k = 0; k < 13; k++) exp_q.push_back(tbl[k]);
    for (int i = 0; i < 13; i++) begin
      check_eq($sformatf("valid_idx%0d", i), {31'd0, tx_if.tx_valid}, 32'd1);
      check_eq($sformatf("data_idx%0d", i), {24'd0, tx_if.tx_data}, {24'd0, exp_q[0]});
      if (i == chg_at) set_time(~sw_mode, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1);
      if (req_at[i]) req = 1'b1;
      if (i == stall_at) begin
        tx_if.tx_ready = 1'b0;
        for (int s = 1; s < stall_len; s++) begin
          step();
          check_eq("stall_valid", {31'd0, tx_if.tx_valid}, 32'd1);
          check_eq("stall_data", {24'd0, tx_if.tx_data}, {24'd0, exp_q[0]});
        end
        tx_if.tx_ready = 1'b1;
      end
      step();
      req = 1'b0;
      void'(exp_q.pop_front());
    end
    check_eq("done_pulse", {31'd0, frame_done}, 32'd1);
    check_eq("done_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check_eq("done_state", {30'd0, dbg_state}, 32'd2);
  endtask

  task automatic run_window(input int tick_cycles, input int req_cycle, input int ncycles,
                            output int rises, output int first);
    logic prev;
    prev  = 1'b0;
    rises = 0;
    first = -1;
    for (int c = 0; c < ncycles; c++) begin
      tick_100hz = (c < tick_cycles);
      req        = (c == req_cycle);
      step();
      if (tx_if.tx_valid && !prev) begin
        rises++;
        if (first < 0) first = c + 1;
      end
      prev = tx_if.tx_valid;
    end
    tick_100hz = 1'b0;
    req        = 1'b0;
  endtask

  logic [7:0] tbl_cl [13] = '{8'h43, 8'h4C, 8'h20, 8'h31, 8'h32, 8'h3A, 8'h33,
                              8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
  logic [7:0] tbl_sw [13] = '{8'h53, 8'h57, 8'h20, 8'h39, 8'h38, 8'h3A, 8'h37,
                              8'h30, 8'h3A, 8'h35, 8'h3F, 8'h0D, 8'h0A};

  initial begin
    int rises;
    int first;

    rst = 1'b0; req = 1'b0; tick_100hz = 1'b0;
    tx_if.tx_ready = 1'b1;
    set_time(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    do_reset();

    check_eq("rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check_eq("rst_data", {24'd0, tx_if.tx_data}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, frame_done}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    step();
    check_eq("idle_ready_no_effect", {31'd0, tx_if.tx_valid}, 32'd0);

    // Plain CL frame: valid the cycle after req, DONE 14 cycles after req.
    pulse_req();
    check_eq("start_busy", {31'd0, busy}, 32'd1);
    run_frame(tbl_cl, -1, 0, -1, 13'd0);
    step();
    check_eq("after_done_pulse", {31'd0, frame_done}, 32'd0);
    check_eq("after_done_busy", {31'd0, busy}, 32'd0);

    // Three-cycle stall on the ':' at idx 5.
    pulse_req();
    run_frame(tbl_cl, 5, 3, -1, 13'd0);
    step();

    // SW frame with an invalid seconds digit; inputs change mid-frame.
    set_time(1'b0, 4'd9, 4'd8, 4'd7, 4'd0, 4'd5, 4'hB);
    pulse_req();
    run_frame(tbl_sw, -1, 0, 2, 13'd0);
    step();

    // Three reqs during a frame give exactly one extra frame.
    set_time(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    pulse_req();
    run_frame(tbl_cl, -1, 0, -1, 13'b0000001011000);
    step();
    check_eq("gap_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check_eq("gap_busy", {31'd0, busy}, 32'd0);
    step();
    run_frame(tbl_cl, -1, 0, -1, 13'd0);
    for (int k = 0; k < 6; k++) step();
    check_eq("no_third_frame", {31'd0, tx_if.tx_valid}, 32'd0);

    // A req in the DONE cycle is remembered.
    pulse_req();
    run_frame(tbl_cl, -1, 0, -1, 13'd0);
    pulse_req();
    check_eq("done_req_gap", {31'd0, tx_if.tx_valid}, 32'd0);
    step();
    run_frame(tbl_cl, -1, 0, -1, 13'd0);
    step();

    // Reset at idx 7 aborts the frame without frame_done.
    pulse_req();
    for (int k = 0; k < 7; k++) step();
    check_eq("pre_abort_data", {24'd0, tx_if.tx_data}, 32'h34);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_eq("abort_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, frame_done}, 32'd0);
    step();
    check_eq("abort_no_resume", {31'd0, tx_if.tx_valid}, 32'd0);
    check_eq("abort_no_done", {31'd0, frame_done}, 32'd0);
    pulse_req();
    run_frame(tbl_cl, -1, 0, -1, 13'd0);
    step();

`ifdef TIME_REPORT_AUTO_EN
    do_reset();
    run_window(4, -1, 40, rises, first);
    check_eq("auto_rises", rises, 32'd1);
    check_eq("auto_first", first, 32'd4);
    do_reset();
    run_window(4, 3, 40, rises, first);
    check_eq("auto_req_merge_rises", rises, 32'd1);
    check_eq("auto_req_merge_first", first, 32'd4);
    do_reset();
    run_window(4, 1, 50, rises, first);
    check_eq("auto_pending_rises", rises, 32'd2);
    check_eq("auto_pending_first", first, 32'd2);
`else
    do_reset();
    run_window(12, -1, 30, rises, first);
    check_eq("tick_ignored", rises, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_report_ctrl.md
TIME_REPORT_CTRL -- requirements
Module: time_report_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the character width of tx_data.
REQ-002 Parameter AUTO_PERIOD, default 100, SHALL set the tick_100hz count between automatic reports (used only with TIME_REPORT_AUTO_EN).
REQ-003 clk  input  1  SHALL be the single clock; all logic SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req  input  1  SHALL be a one-cycle report request pulse.
REQ-006 tick_100hz  input  1  SHALL be a one-cycle 100 Hz time base.
REQ-007 sw_mode  input  1  SHALL select the frame prefix: 1 gives "CL" (clock), 0 gives "SW" (stopwatch).
REQ-008 hour1, hour0, min1, min0, sec1, sec0  input  4 each  SHALL be the BCD time digits.
REQ-009 tx_ready  input  1  SHALL be the downstream UART TX ready.
REQ-010 tx_valid  output  1  SHALL indicate that tx_data holds a character.
REQ-011 tx_data  output  DATA_WIDTH  SHALL be the ASCII character.
REQ-012 busy  output  1  SHALL be high from frame start until frame_done.
REQ-013 frame_done  output  1  SHALL pulse for one cycle after the last character is accepted.

Function
REQ-014 The frame SHALL be 13 characters, idx 0..12:
- prefix char 0, prefix char 1, 0x20
- hour1, hour0, 0x3A
- min1, min0, 0x3A
- sec1, sec0, 0x0D, 0x0A
REQ-015 Digit conversion: a digit 0..9 SHALL map to 0x30+digit; a digit 10..15 SHALL map to 0x3F ('?').
REQ-016 FSM states: IDLE, SEND, DONE.
REQ-017 IDLE -> SEND on a start event (req, pending or auto); in that same edge, all six digits and sw_mode SHALL be snapshotted and idx SHALL be set to 0.
REQ-018 In SEND, tx_valid SHALL be 1 and tx_data SHALL equal char[idx].
REQ-019 Latency: a start event in cycle N SHALL give tx_valid=1 in cycle N+1.
REQ-020 Handshake: a character transfers on a cycle with tx_valid && tx_ready. Until then, tx_data SHALL stay stable and tx_valid SHALL not drop.
REQ-021 On a transfer: if idx<12, idx SHALL increment; if idx==12, the FSM SHALL go to DONE.
REQ-022 In DONE: frame_done=1 and tx_valid=0 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-023 Frame content SHALL come only from the snapshot; input changes during a frame SHALL not alter it.
REQ-024 A req while busy SHALL set a 1-deep pending flag; further reqs while the flag is set SHALL be dropped.
REQ-025 The pending flag SHALL be consumed as a start event in the IDLE cycle after DONE; back-to-back frames therefore have one idle cycle between them.
REQ-026 A req in the same cycle as DONE SHALL set pending.
REQ-027 tx_ready while tx_valid=0 SHALL have no effect.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL reset to:
- state IDLE, idx 0, pending 0, snapshot 0
- tx_valid 0, tx_data 0x00, busy 0, frame_done 0
- auto counter 0
REQ-029 A reset mid-frame SHALL abort the frame immediately; no frame_done SHALL be issued and the frame SHALL not resume.

Configuration
REQ-030 Macro TIME_REPORT_AUTO_EN, when defined, SHALL add a counter that increments on tick_100hz and wraps at AUTO_PERIOD-1.
- On wrap, it SHALL generate an auto start event.
- The auto event SHALL be treated exactly like req (start if IDLE, else pending).
- req and auto in the same cycle SHALL count as a single start event.
REQ-031 Without TIME_REPORT_AUTO_EN, the counter logic SHALL be absent, tick_100hz SHALL be ignored, and frames SHALL start only from req/pending.

Verification
REQ-032 sw_mode=1, digits 1,2,3,4,5,6, req pulse, tx_ready=1 -> cycles N+1..N+13 carry 43 4C 20 31 32 3A 33 34 3A 35 36 0D 0A; frame_done at N+14.
REQ-033 Same frame with tx_ready low for 3 cycles at idx 5 -> tx_data=0x3A held with tx_valid=1 for all 3 cycles; no characters lost or duplicated.
REQ-034 sw_mode=0, sec0=0xB, req; change digits at idx 2 -> prefix 53 57, sec0 char 0x3F, remaining characters from the snapshot.
REQ-035 Three reqs during a frame -> exactly two frames total; second frame's tx_valid rises two cycles after the first frame_done.
REQ-036 rst=0 at idx 7 -> next cycle tx_valid=0, busy=0, no frame_done; a fresh req restarts at idx 0.
REQ-037 With TIME_REPORT_AUTO_EN, AUTO_PERIOD=4, continuous tick_100hz, tx_ready=1 -> a frame starts every 4 ticks when idle; req coinciding with wrap yields one frame.
